// File: rtl/csr_ctrl_if.sv
// Request / response / CSR-file port bundle for csr_ctrl.
// The slave modport is the sequencer; the master modport is the pipeline and CSR file side.
interface csr_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [CSR_AW-1:0] req_csr;
  logic [XLEN-1:0]   req_src;
  logic [4:0]        req_zimm;
  logic              req_rs1_zero;
  logic [XLEN-1:0]   req_pc;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rd_data;
  logic              resp_redirect;
  logic [XLEN-1:0]   resp_target;

  logic [CSR_AW-1:0] csr_idx;
  logic              csr_wr_en;
  logic [XLEN-1:0]   csr_wr_data;
  logic [XLEN-1:0]   csr_rd_data;

  modport master (
    output req_valid, req_op, req_csr, req_src, req_zimm, req_rs1_zero, req_pc,
    output resp_ready, csr_rd_data,
    input  req_ready, resp_valid, resp_rd_data, resp_redirect, resp_target,
    input  csr_idx, csr_wr_en, csr_wr_data
  );

  modport slave (
    input  req_valid, req_op, req_csr, req_src, req_zimm, req_rs1_zero, req_pc,
    input  resp_ready, csr_rd_data,
    output req_ready, resp_valid, resp_rd_data, resp_redirect, resp_target,
    output csr_idx, csr_wr_en, csr_wr_data
  );
endinterface

// File: rtl/csr_ctrl.sv
// CSR/trap sequencer: runs Zicsr, ECALL and MRET as ordered accesses to a single-port CSR file.
// Optional macro CSR_ILLEGAL_CHECK_EN turns writes to read-only CSRs into an illegal-instruction trap.
module csr_ctrl #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input logic       clk,
  input logic       rst_n,
  csr_ctrl_if.slave bus
);
  localparam logic [CSR_AW-1:0] MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] MCAUSE  = CSR_AW'(12'h342);

  typedef enum logic [3:0] {
    S_IDLE, S_CSR, S_T_EPC, S_T_CAUSE, S_T_STATUS, S_T_VEC, S_M_STATUS, S_M_EPC, S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        fn_q;
  logic [CSR_AW-1:0] csr_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   pc_q;
  logic              src_nz_q;
  logic              ill_q;
  logic [XLEN-1:0]   rd_q;
  logic [XLEN-1:0]   tgt_q;
  logic              redir_q;

  logic req_hs;
  logic wr_req;
  logic illegal;

  assign req_hs = bus.req_valid && bus.req_ready;
  // CSRRW/CSRRWI always write; set/clear only when the operand source is nonzero.
  assign wr_req = (fn_q == 2'b01) || src_nz_q;

`ifdef CSR_ILLEGAL_CHECK_EN
  assign illegal = wr_req && (csr_q[CSR_AW-1 -: 2] == 2'b11);
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            3'b000:  state_nxt = S_T_EPC;
            3'b100:  state_nxt = S_M_STATUS;
            default: state_nxt = S_CSR;
          endcase
        end
      end
      S_CSR:      state_nxt = illegal ? S_T_EPC : S_RESP;
      S_T_EPC:    state_nxt = S_T_CAUSE;
      S_T_CAUSE:  state_nxt = S_T_STATUS;
      S_T_STATUS: state_nxt = S_T_VEC;
      S_T_VEC:    state_nxt = S_RESP;
      S_M_STATUS: state_nxt = S_M_EPC;
      S_M_EPC:    state_nxt = S_RESP;
      S_RESP:     if (bus.resp_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Address and strobe are gated by rst_n so a reset edge never coincides with a write.
  always_comb begin
    bus.req_ready  = rst_n && (state == S_IDLE);
    bus.resp_valid = (state == S_RESP);
    bus.csr_idx    = '0;
    bus.csr_wr_en  = 1'b0;
    case (state)
      S_CSR: begin
        bus.csr_idx   = csr_q;
        bus.csr_wr_en = wr_req && !illegal;
      end
      S_T_EPC:    begin bus.csr_idx = MEPC;    bus.csr_wr_en = 1'b1; end
      S_T_CAUSE:  begin bus.csr_idx = MCAUSE;  bus.csr_wr_en = 1'b1; end
      S_T_STATUS: begin bus.csr_idx = MSTATUS; bus.csr_wr_en = 1'b1; end
      S_T_VEC:    bus.csr_idx = MTVEC;
      S_M_STATUS: begin bus.csr_idx = MSTATUS; bus.csr_wr_en = 1'b1; end
      S_M_EPC:    bus.csr_idx = MEPC;
      default: ;
    endcase
    if (!rst_n) begin
      bus.csr_idx   = '0;
      bus.csr_wr_en = 1'b0;
    end
  end

  // Kept apart from the address block: write data depends on the combinational read of csr_idx.
  always_comb begin
    bus.csr_wr_data = '0;
    case (state)
      S_CSR: begin
        case (fn_q)
          2'b10:   bus.csr_wr_data = bus.csr_rd_data | opnd_q;
          2'b11:   bus.csr_wr_data = bus.csr_rd_data & ~opnd_q;
          default: bus.csr_wr_data = opnd_q;
        endcase
      end
      S_T_EPC:   bus.csr_wr_data = pc_q;
      S_T_CAUSE: bus.csr_wr_data = ill_q ? XLEN'(2) : XLEN'(11);
      S_T_STATUS: begin
        bus.csr_wr_data        = bus.csr_rd_data;
        bus.csr_wr_data[7]     = bus.csr_rd_data[3];
        bus.csr_wr_data[3]     = 1'b0;
        bus.csr_wr_data[12:11] = 2'b11;
      end
      S_M_STATUS: begin
        bus.csr_wr_data        = bus.csr_rd_data;
        bus.csr_wr_data[3]     = bus.csr_rd_data[7];
        bus.csr_wr_data[7]     = 1'b1;
        bus.csr_wr_data[12:11] = 2'b11;
      end
      default: ;
    endcase
    if (!rst_n) bus.csr_wr_data = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fn_q     <= '0;
      csr_q    <= '0;
      opnd_q   <= '0;
      pc_q     <= '0;
      src_nz_q <= 1'b0;
      ill_q    <= 1'b0;
      rd_q     <= '0;
      tgt_q    <= '0;
      redir_q  <= 1'b0;
    end else begin
      if (req_hs) begin
        fn_q     <= bus.req_op[1:0];
        csr_q    <= bus.req_csr;
        opnd_q   <= bus.req_op[2] ? {{(XLEN-5){1'b0}}, bus.req_zimm} : bus.req_src;
        src_nz_q <= bus.req_op[2] ? (bus.req_zimm != 5'd0) : !bus.req_rs1_zero;
        pc_q     <= bus.req_pc;
        ill_q    <= 1'b0;
        rd_q     <= '0;
        tgt_q    <= '0;
        redir_q  <= 1'b0;
      end
      if (state == S_CSR) begin
        ill_q <= illegal;
        if (!illegal) rd_q <= bus.csr_rd_data;
      end
      if (state == S_T_VEC) begin
        tgt_q   <= {bus.csr_rd_data[XLEN-1:2], 2'b00};
        redir_q <= 1'b1;
      end
      if (state == S_M_EPC) begin
        tgt_q   <= bus.csr_rd_data;
        redir_q <= 1'b1;
      end
    end
  end

  assign bus.resp_rd_data  = rd_q;
  assign bus.resp_target   = tgt_q;
  assign bus.resp_redirect = redir_q;
endmodule

// File: doc/csr_ctrl.md
# csr_ctrl

CSR/trap sequencer that initiates all accesses to the single-port machine CSR register file (mepc 0x341, mtvec 0x305, mstatus 0x300, mcause 0x342). It sits in the execute stage and accepts one decoded SYSTEM instruction at a time: Zicsr ops, ECALL or MRET. For each it issues the required sequence of CSR reads and writes, then returns rd data or a PC redirect over a valid/ready response handshake.

## Interface
- XLEN, 64, data width
- CSR_AW, 12, CSR address width
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  3  funct3 encoding: 000 ECALL, 001 CSRRW, 010 CSRRS, 011 CSRRC, 100 MRET, 101 CSRRWI, 110 CSRRSI, 111 CSRRCI
- req_csr  in  CSR_AW  target CSR address
- req_src  in  XLEN  rs1 value, register forms
- req_zimm  in  5  immediate, immediate forms
- req_rs1_zero  in  1  rs1 field is x0
- req_pc  in  XLEN  PC of the instruction
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts
- resp_rd_data  out  XLEN  old CSR value, 0 for ECALL/MRET
- resp_redirect  out  1  resp_target is the next PC
- resp_target  out  XLEN  redirect PC
- csr_idx  out  CSR_AW  CSR file address; 0 when no access
- csr_wr_en  out  1  CSR write strobe
- csr_wr_data  out  XLEN  CSR write data
- csr_rd_data  in  XLEN  combinational read of csr_idx

## Operation
- All request fields are latched on the req_valid & req_ready handshake. The operand is req_src for register forms, {59'b0, req_zimm} for immediate forms.
- IDLE: req_ready=1. An accepted request moves to CSR (Zicsr), T_EPC (ECALL) or M_STATUS (MRET).
- CSR: csr_idx=req_csr.
  - csr_rd_data is captured into resp_rd_data.
  - Write data: RW = operand; RS = old|operand; RC = old&~operand.
  - csr_wr_en=1 for RW/RWI always. For RS/RC it is 1 only if the operand source is nonzero: register forms need req_rs1_zero=0; immediate forms need zimm≠0.
  - Next state: RESP.
- T_EPC: writes req_pc to 0x341 (mepc = PC of the ecall, not PC+4).
- T_CAUSE: writes 11 to 0x342.
- T_STATUS: reads 0x300, then writes it back with bit7 (MPIE) = old bit3 (MIE), bit3=0, bits[12:11] (MPP)=2'b11.
- T_VEC: reads 0x305 with no write; resp_target={rd[XLEN-1:2],2'b00}.
- M_STATUS: reads 0x300, then writes it back with bit3=old bit7, bit7=1, bits[12:11]=2'b11.
- M_EPC: reads 0x341 with no write; resp_target=value.
- RESP: resp_valid=1.
  - resp_redirect=1 after T_VEC/M_EPC, otherwise 0.
  - Outputs are held stable until resp_ready; then the block returns to IDLE.
- Outside the write states, csr_wr_en=0. Outside all access states, csr_idx=0 and csr_wr_data=0.

## Timing
- Reset (rst_n=0 at posedge): state=IDLE; resp_valid, resp_redirect, resp_rd_data, resp_target, csr_wr_en, csr_idx, csr_wr_data all 0. req_ready is 0 while rst_n is low.
- Latency counts handshake edge = cycle 0 to the first resp_valid cycle, with resp_ready held high:
  - Zicsr: CSR write in cycle 1, resp_valid in cycle 2.
  - ECALL: writes in cycles 1-3, mtvec read in cycle 4, resp_valid in cycle 5.
  - MRET: cycles 1-2 for CSR access, resp_valid in cycle 3.
- Throughput: the next request is accepted at the earliest in the cycle after the response handshake. There is no overlap.
- Back-pressure: if resp_ready=0, the block stays in RESP indefinitely and issues no CSR access.
- Reset mid-sequence: the block aborts at that edge and issues no further writes. Writes already committed (e.g. mepc) remain in the CSR file.
- A Zicsr write to mstatus/mepc uses plain RMW; there is no hazard with the trap states because they are never concurrent.

## Configuration
- CSR_ILLEGAL_CHECK_EN defined: a Zicsr request that would assert csr_wr_en and has req_csr[11:10]==2'b11 (read-only space) issues no write. Instead it runs the ECALL sequence with mcause=2; resp_rd_data=0 and resp_redirect=1.
- CSR_ILLEGAL_CHECK_EN undefined: the write is issued as normal, and the CSR file decides whether to ignore it. A CSRRS with zero operand to a read-only CSR is legal in both builds.

## Test plan
- CSRRW 0x305, src=0x8000_1000, mtvec=0 -> cycle 1 write 0x8000_1000 to 0x305; resp_rd_data=0, resp_valid at cycle 2.
- CSRRS 0x300 with req_rs1_zero=1, mstatus=0xA00001800 -> csr_wr_en stays 0; resp_rd_data=0xA00001800.
- ECALL pc=0x8000_0040, mstatus bit3=1, mtvec=0x8000_1001 -> writes mepc=0x8000_0040, mcause=11, mstatus bit7=1/bit3=0; resp_redirect=1, resp_target=0x8000_1000 at cycle 5.
- MRET with mepc=0x8000_0044, mstatus bit7=1 -> mstatus bit3=1, bit7=1; resp_target=0x8000_0044 at cycle 3.
- CSRRCI 0x342 zimm=3 with resp_ready low for 4 cycles -> exactly one write (old&~3); response is held stable; next req_ready only after the handshake.
- CSRRW 0xC00 -> with CSR_ILLEGAL_CHECK_EN: mcause=2, redirect to mtvec. Without it: write to 0xC00 issued.
